// File: rtl/mem_interface_unit.sv
// Load/store bridge from the instruction unit to a byte-wide memory port.
// Optional mem_resp watchdog is enabled by defining MIU_TIMEOUT_EN.
module mem_interface_unit #(
    parameter int ADDR_W         = 14,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic              store,
    input  logic [ADDR_W-1:0] addr,
    input  logic [15:0]       result,
    output logic [7:0]        data,
    output logic              mem_done,
    output logic              err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_resp
);

    typedef enum logic [2:0] {
        S_IDLE, S_LD, S_ST_LO, S_ST_HI, S_DONE, S_DRAIN
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        data_q, data_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] maddr_q, maddr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [ADDR_W-1:0] caddr_q, caddr_d;
    logic [7:0]        hi_q, hi_d;
    logic              abort;

`ifdef MIU_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;

    assign abort = req_q && !mem_resp
                && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout;

    assign abort          = 1'b0;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        done_d  = 1'b0;
        err_d   = err_q;
        req_d   = req_q;
        we_d    = we_q;
        maddr_d = maddr_q;
        wdata_d = wdata_q;
        caddr_d = caddr_q;
        hi_d    = hi_q;
        unique case (state_q)
            S_IDLE: begin
                if (load && store) begin
                    err_d   = 1'b1;
                    state_d = S_DRAIN;
                end else if (load) begin
                    state_d = S_LD;
                    req_d   = 1'b1;
                    we_d    = 1'b0;
                    maddr_d = addr;
                    caddr_d = addr;
                end else if (store) begin
                    state_d = S_ST_LO;
                    req_d   = 1'b1;
                    we_d    = 1'b1;
                    maddr_d = addr;
                    caddr_d = addr;
                    wdata_d = result[7:0];
                    hi_d    = result[15:8];
                end
            end
            S_LD: begin
                if (mem_resp || abort) begin
                    data_d  = mem_resp ? mem_rdata : 8'h00;
                    err_d   = err_q | ~mem_resp;
                    req_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_ST_LO: begin
                if (mem_resp) begin
                    state_d = S_ST_HI;
                    maddr_d = caddr_q + ADDR_W'(1);
                    wdata_d = hi_q;
                end else if (abort) begin
                    err_d   = 1'b1;
                    req_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_ST_HI: begin
                if (mem_resp || abort) begin
                    err_d   = err_q | ~mem_resp;
                    req_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_DRAIN;
            S_DRAIN: begin
                // Held requests must be seen low before re-arming
                if (!load && !store) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef MIU_TIMEOUT_EN
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q)
            cnt_d = '0;
        else if (req_q && !mem_resp)
            cnt_d = cnt_q + CW'(1);
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            maddr_q <= '0;
            wdata_q <= '0;
            caddr_q <= '0;
            hi_q    <= '0;
`ifdef MIU_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
            req_q   <= req_d;
            we_q    <= we_d;
            maddr_q <= maddr_d;
            wdata_q <= wdata_d;
            caddr_q <= caddr_d;
            hi_q    <= hi_d;
`ifdef MIU_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign data      = data_q;
    assign mem_done  = done_q;
    assign err       = err_q;
    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = maddr_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_interface_unit.sv
// Scoreboard bench for mem_interface_unit with a latency-programmable
// byte memory responder.
module tb_mem_interface_unit;

`ifdef MIU_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 255;
`endif

    logic        clk = 0;
    logic        reset_n, load, store;
    logic [13:0] addr;
    logic [15:0] result;
    logic [7:0]  data;
    logic        mem_done, err, mem_req, mem_we;
    logic [13:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        mem_resp;

    mem_interface_unit #(.ADDR_W(14), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset_n(reset_n), .load(load), .store(store),
        .addr(addr), .result(result), .data(data),
        .mem_done(mem_done), .err(err), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_resp(mem_resp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [13:0] a;
        logic [7:0]  wd;
    } acc_t;
    typedef struct {
        logic [7:0] d;
        logic       e;
    } done_t;

    acc_t  exp_acc[$];
    done_t exp_done[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int lat = 0;
    bit resp_en = 1;
    logic [7:0] rd_byte = 8'h00;
    logic [7:0] last_data = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Memory responder: answers after lat extra cycles of mem_req
    initial begin
        int wc;
        wc = 0;
        mem_resp = 0;
        mem_rdata = 0;
        forever begin
            @(negedge clk);
            mem_resp = 0;
            if (mem_req === 1'b1 && resp_en) begin
                if (wc == lat) begin
                    mem_resp = 1;
                    mem_rdata = rd_byte;
                    wc = 0;
                end else begin
                    wc++;
                end
            end else begin
                wc = 0;
            end
        end
    end

    // Monitor: compares every memory handshake and completion
    initial begin
        acc_t  ea;
        done_t ed;
        forever begin
            @(negedge clk);
            #1;
            if (mem_req === 1'b1 && mem_resp === 1'b1) begin
                if (exp_acc.size() == 0) begin
                    chk("unexpected_access", {18'b0, mem_addr}, 32'hFFFF);
                end else begin
                    ea = exp_acc.pop_front();
                    chk("acc_we", {31'b0, mem_we}, {31'b0, ea.we});
                    chk("acc_addr", {18'b0, mem_addr}, {18'b0, ea.a});
                    if (ea.we)
                        chk("acc_wdata", {24'b0, mem_wdata}, {24'b0, ea.wd});
                end
            end
            if (mem_done === 1'b1) begin
                if (exp_done.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    ed = exp_done.pop_front();
                    chk("done_data", {24'b0, data}, {24'b0, ed.d});
                    chk("done_err", {31'b0, err}, {31'b0, ed.e});
                end
            end
        end
    end

    task automatic wait_done(output int dcyc, output int gaps,
                             output int reqc);
        dcyc = -1;
        gaps = 0;
        reqc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #2;
            if (mem_done === 1'b1) begin
                dcyc = cyc;
                break;
            end
            if (mem_req === 1'b1) reqc++;
            else gaps++;
        end
        if (dcyc < 0) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic start_load(input logic [13:0] a, input logic [7:0] rd,
                              input int l, output int st);
        @(negedge clk);
        lat = l;
        rd_byte = rd;
        addr = a;
        load = 1;
        st = cyc;
        exp_acc.push_back('{1'b0, a, 8'h00});
        last_data = rd;
        exp_done.push_back('{rd, 1'b0});
    endtask

    task automatic start_store(input logic [13:0] a, input logic [15:0] r,
                               input int l, output int st);
        @(negedge clk);
        lat = l;
        addr = a;
        result = r;
        store = 1;
        st = cyc;
        exp_acc.push_back('{1'b1, a, r[7:0]});
        exp_acc.push_back('{1'b1, a + 14'd1, r[15:8]});
        exp_done.push_back('{last_data, 1'b0});
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int st, dc, gp, rq;
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timed out");
    end

    initial begin
        int st, dc, gp, rq;
        reset_n = 0;
        load = 0;
        store = 0;
        addr = 0;
        result = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2;
        chk("rst_req", {31'b0, mem_req}, 0);
        chk("rst_done", {31'b0, mem_done}, 0);
        chk("rst_err", {31'b0, err}, 0);
        chk("rst_data", {24'b0, data}, 0);
        reset_n = 1;

        // Load, immediate response
        start_load(14'h0010, 8'h5A, 0, st);
        wait_done(dc, gp, rq);
        chk("ld_latency", dc - st, 2);
        load = 0;
        idle(2);

        // Store with 3-cycle memory latency, continuous mem_req
        start_store(14'h0012, 16'hBEEF, 2, st);
        wait_done(dc, gp, rq);
        chk("st_req_gaps", gp, 0);
        chk("st_latency", dc - st, 7);
        store = 0;
        idle(2);

        // Store wrap-around
        start_store(14'h3FFF, 16'h1234, 0, st);
        wait_done(dc, gp, rq);
        chk("wrap_latency", dc - st, 3);
        store = 0;
        idle(2);

        // Held load: no re-acceptance until load seen low
        start_load(14'h0020, 8'hC3, 0, st);
        wait_done(dc, gp, rq);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #2;
            chk("held_no_req", {31'b0, mem_req}, 0);
        end
        load = 0;
        start_load(14'h0021, 8'h77, 1, st);
        wait_done(dc, gp, rq);
        chk("reload_data", {24'b0, data}, 32'h77);
        load = 0;
        idle(2);

        // Protocol error
        @(negedge clk);
        addr = 14'h0030;
        load = 1;
        store = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #2;
            chk("perr_no_req", {31'b0, mem_req}, 0);
        end
        chk("perr_err", {31'b0, err}, 1);
        load = 0;
        store = 0;
        idle(2);

        // Reset while in ST_HI
        @(negedge clk);
        lat = 0;
        addr = 14'h0040;
        result = 16'hAA55;
        store = 1;
        exp_acc.push_back('{1'b1, 14'h0040, 8'h55});
        @(negedge clk);
        #2;
        resp_en = 0;
        @(negedge clk);
        #2;
        chk("sthi_req", {31'b0, mem_req}, 1);
        chk("sthi_addr", {18'b0, mem_addr}, 32'h41);
        chk("sthi_wdata", {24'b0, mem_wdata}, 32'hAA);
        reset_n = 0;
        @(negedge clk);
        #2;
        chk("mrst_req", {31'b0, mem_req}, 0);
        chk("mrst_we", {31'b0, mem_we}, 0);
        chk("mrst_addr", {18'b0, mem_addr}, 0);
        chk("mrst_wdata", {24'b0, mem_wdata}, 0);
        chk("mrst_data", {24'b0, data}, 0);
        chk("mrst_done", {31'b0, mem_done}, 0);
        chk("mrst_err", {31'b0, err}, 0);
        reset_n = 1;
        store = 0;
        last_data = 8'h00;
        idle(4);
        resp_en = 1;

`ifdef MIU_TIMEOUT_EN
        // Load with no response ever returned
        @(negedge clk);
        resp_en = 0;
        addr = 14'h0050;
        load = 1;
        st = cyc;
        exp_done.push_back('{8'h00, 1'b1});
        wait_done(dc, gp, rq);
        chk("to_req_cycles", rq, 4);
        chk("to_data", {24'b0, data}, 0);
        chk("to_err", {31'b0, err}, 1);
        load = 0;
        idle(3);
        resp_en = 1;
`endif

        idle(3);
        chk("acc_queue_empty", exp_acc.size(), 0);
        chk("done_queue_empty", exp_done.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
